// File: rtl/sd_ring_mod_pkg.sv
`default_nettype none
//==============================================================================
// Package     : sd_pkg
// Description : Shared helpers for the ring sigma-delta modulator: clog2,
//               per-stage accumulator reset value and a width-parameterised
//               saturating/wrapping add with overflow detection.
// Revision    : 1.0 - initial release
//==============================================================================
package sd_pkg;

    // Widest accumulator the helpers below can carry
    localparam int unsigned SD_MAXW = 64;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = 32'(i) + 32'd1;
            end
        end
        return result;
    endfunction

    // Stage 0 starts at mid-scale so the ring does not sit in a dead state
    function automatic logic [SD_MAXW-1:0] acc_rst_val(input int unsigned idx,
                                                       input int unsigned width);
        logic [SD_MAXW-1:0] value;
        value = '0;
        if (idx == 0) begin
            value = 64'd1 << (width - 1);
        end
        return value;
    endfunction

    // Adds an unsigned width-bit accumulator and a signed delta.
    // Returns {overflow, result}; result is clamped when sat is set,
    // otherwise reduced modulo 2^width.
    function automatic logic [SD_MAXW:0] sat_add(input logic [SD_MAXW-1:0]   a,
                                                 input logic signed [SD_MAXW+1:0] b,
                                                 input int unsigned           width,
                                                 input logic                  sat);
        logic signed [SD_MAXW+2:0] sum;
        logic [SD_MAXW-1:0]        max;
        logic                      neg;
        logic                      over;
        logic [SD_MAXW-1:0]        res;
        max  = (width >= SD_MAXW) ? {SD_MAXW{1'b1}} : ((64'd1 << width) - 64'd1);
        sum  = $signed({3'b000, a}) + $signed({b[SD_MAXW+1], b});
        neg  = sum[SD_MAXW+2];
        over = neg || (sum[SD_MAXW+1:0] > {2'b00, max});
        res  = sum[SD_MAXW-1:0] & max;
        if (over && sat) begin
            res = neg ? '0 : max;
        end
        return {over, res};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_ring_mod_if.sv
`default_nettype none
//==============================================================================
// Interface   : sd_ring_mod_if
// Description : Valid/ready coefficient-load channel of the ring modulator.
// Revision    : 1.0 - initial release
//==============================================================================
interface sd_ring_mod_if #(
    parameter int BITWIDTH = 32
);
    logic [BITWIDTH-1:0] kin;
    logic                kin_valid;
    logic                kin_ready;

    modport master (output kin, output kin_valid, input kin_ready);
    modport slave  (input kin, input kin_valid, output kin_ready);
endinterface
`default_nettype wire

// File: rtl/sd_ring_mod_tap_quant.sv
`default_nettype none
//==============================================================================
// Module      : sd_tap_quant
// Description : First-order quantiser on an accumulator MSB tap; the carry
//               out of the TAPW-bit integrator is the output bit.
// Revision    : 1.0 - initial release
//==============================================================================
module sd_tap_quant #(
    parameter int TAPW = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            clr,
    input  logic [TAPW-1:0] tap,
    output logic            bit_out
);
    logic [TAPW-1:0] r_q;
    logic [TAPW:0]   w_sum;

    assign w_sum = {1'b0, r_q} + {1'b0, tap};

    // Integrate the tap; clear wins over enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q     <= '0;
            bit_out <= 1'b0;
        end else if (clr) begin
            r_q     <= '0;
            bit_out <= 1'b0;
        end else if (en) begin
            r_q     <= w_sum[TAPW-1:0];
            bit_out <= w_sum[TAPW];
        end
    end
endmodule
`default_nettype wire

// File: rtl/sd_ring_mod.sv
`default_nettype none
//==============================================================================
// Module      : sd_ring_mod
// Description : N-phase ring sigma-delta modulator. Each stage's coefficient
//               polarity is steered by the previous stage's output bit;
//               coefficients load through a shadow register and commit at the
//               frame boundary.
// Revision    : 1.0 - initial release
//==============================================================================
module sd_ring_mod
    import sd_pkg::*;
#(
    parameter int  BITWIDTH = 32,
    parameter int  NPHASE   = 2,
    parameter int  TAPW     = 12,
    parameter int  SAT      = 0,
    localparam int PHW      = (clog2(NPHASE) > 1) ? clog2(NPHASE) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    sd_ring_mod_if.slave      kif,
    output logic [NPHASE-1:0] sd_out,
    output logic [PHW-1:0]    phase,
    output logic              ovf
);
    localparam int       c_sw         = BITWIDTH + 2;
    localparam logic [0:0] c_st_empty   = 1'b0;
    localparam logic [0:0] c_st_pending = 1'b1;

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic [BITWIDTH-1:0]     r_k_act;
    logic [BITWIDTH-1:0]     r_k_shadow;
    logic [PHW-1:0]          r_phase;
    logic                    r_ovf;
    logic                    w_advance;
    logic                    w_last;
    logic                    w_accept;
    logic                    w_commit;
    logic [NPHASE-1:0]       w_sd;
    logic [NPHASE-1:0]       w_stage_ovf;
    logic signed [c_sw-1:0]  w_kpos;

    assign w_advance = en && !clr;
    assign w_last    = (r_phase == PHW'(NPHASE - 1));
    assign w_kpos    = c_sw'($signed(r_k_act));

    // Load FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Load FSM next state: accept fills the shadow, frame-end commit drains it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_empty:   if (w_accept) w_state_nxt = c_st_pending;
            c_st_pending: if (w_commit) w_state_nxt = c_st_empty;
            default:      w_state_nxt = c_st_empty;
        endcase
    end

    // Load FSM outputs; ready depends on the state register only
    always_comb begin
        kif.kin_ready = (r_state == c_st_empty);
        w_accept      = kif.kin_valid && (r_state == c_st_empty);
        w_commit      = (r_state == c_st_pending) && w_advance && w_last;
    end

    // Shadow capture and frame-aligned commit of the coefficient
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k_shadow <= '0;
            r_k_act    <= '0;
        end else begin
            if (w_accept) r_k_shadow <= kif.kin;
            if (w_commit) r_k_act    <= r_k_shadow;
        end
    end

    // Frame position counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
        end else if (clr) begin
            r_phase <= '0;
        end else if (en) begin
            r_phase <= w_last ? '0 : r_phase + PHW'(1);
        end
    end

    // Sticky overflow from any stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_ovf <= 1'b0;
        end else if (en && (|w_stage_ovf)) begin
            r_ovf <= 1'b1;
        end
    end

    for (genvar i = 0; i < NPHASE; i++) begin : g_stage
        localparam int         c_prev = (i + NPHASE - 1) % NPHASE;
        localparam logic [63:0] c_rst = acc_rst_val(i, BITWIDTH);
        localparam logic       c_inv  = (i == 0);

        logic [BITWIDTH-1:0]    r_acc;
        logic                   w_sel;
        logic signed [c_sw-1:0] w_kterm;
        logic signed [c_sw-1:0] w_fb;
        logic signed [c_sw-1:0] w_delta;
        logic [64:0]            w_res;
        logic                   w_unused_hi;

        // Stage 0 inverts the steering so the ring does not lock in phase
        assign w_sel       = w_sd[c_prev] ^ c_inv;
        assign w_kterm     = w_sel ? w_kpos : -w_kpos;
        assign w_fb        = w_sd[i] ? {c_sw{1'b1}} : c_sw'(1);
        assign w_delta     = w_kterm + w_fb;
        assign w_res       = sat_add(64'(r_acc), 66'(w_delta), BITWIDTH, SAT != 0);
        assign w_stage_ovf[i] = w_res[64];
        assign w_unused_hi = ^w_res[63:BITWIDTH];

        // Ring accumulator
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_acc <= c_rst[BITWIDTH-1:0];
            end else if (clr) begin
                r_acc <= c_rst[BITWIDTH-1:0];
            end else if (en) begin
                r_acc <= w_res[BITWIDTH-1:0];
            end
        end

        sd_tap_quant #(.TAPW(TAPW)) u_quant (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .clr     (clr),
            .tap     (r_acc[BITWIDTH-1 -: TAPW]),
            .bit_out (w_sd[i])
        );
    end

    assign sd_out = w_sd;
    assign phase  = r_phase;
    assign ovf    = r_ovf;
endmodule
`default_nettype wire
